// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with write-through,
// load-use / branch-operand hazard stall, early branch resolution with IF/ID flush.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFtoID_PC,
  input  logic [31:0] IFtoID_inst,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [31:0] Branch,
  output logic [31:0] IDtoEX_PC,
  output logic [31:0] IDtoEX_rsData,
  output logic [31:0] IDtoEX_rtData,
  output logic [31:0] IDtoEX_imm,
  output logic [4:0]  IDtoEX_rs,
  output logic [4:0]  IDtoEX_rt,
  output logic [4:0]  IDtoEX_rd,
  output logic [5:0]  IDtoEX_op,
  output logic [5:0]  IDtoEX_funct,
  output logic        IDtoEX_valid
);

  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        is_beq;
  logic        is_bne;
  logic        load_use;
  logic        branch_hazard;
  logic        stall;

  assign op     = if_inst[31:26];
  assign rs     = if_inst[25:21];
  assign rt     = if_inst[20:16];
  assign rd     = if_inst[15:11];
  assign funct  = if_inst[5:0];
  assign imm    = {{16{if_inst[15]}}, if_inst[15:0]};
  assign is_beq = (op == 6'h04);
  assign is_bne = (op == 6'h05);

  // Register read with write-through so a same-cycle WB write is seen by ID.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0)
      rs_data = (WB_RegWrite && (WB_WriteReg == rs)) ? WB_WriteData : regs[rs];
    if (rt != 5'd0)
      rt_data = (WB_RegWrite && (WB_WriteReg == rt)) ? WB_WriteData : regs[rt];
  end

  always_comb begin
    load_use      = EX_MemRead && (EX_WriteReg != 5'd0) &&
                    ((EX_WriteReg == rs) || (EX_WriteReg == rt));
    branch_hazard = (is_beq || is_bne) && EX_RegWrite && (EX_WriteReg != 5'd0) &&
                    ((EX_WriteReg == rs) || (EX_WriteReg == rt));
    stall         = load_use || branch_hazard;
    PCWrite       = !stall;
    PCSrc         = !stall && ((is_beq && (rs_data == rt_data)) ||
                               (is_bne && (rs_data != rt_data)));
    Branch        = if_pc + {imm[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc   <= '0;
      if_inst <= '0;
    end else if (!stall) begin
      if (PCSrc) begin
        if_pc   <= '0;
        if_inst <= '0;
      end else begin
        if_pc   <= IFtoID_PC;
        if_inst <= IFtoID_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0)) begin
      regs[WB_WriteReg] <= WB_WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || stall) begin
      IDtoEX_PC     <= '0;
      IDtoEX_rsData <= '0;
      IDtoEX_rtData <= '0;
      IDtoEX_imm    <= '0;
      IDtoEX_rs     <= '0;
      IDtoEX_rt     <= '0;
      IDtoEX_rd     <= '0;
      IDtoEX_op     <= '0;
      IDtoEX_funct  <= '0;
      IDtoEX_valid  <= 1'b0;
    end else begin
      IDtoEX_PC     <= if_pc;
      IDtoEX_rsData <= rs_data;
      IDtoEX_rtData <= rt_data;
      IDtoEX_imm    <= imm;
      IDtoEX_rs     <= rs;
      IDtoEX_rt     <= rt;
      IDtoEX_rd     <= rd;
      IDtoEX_op     <= op;
      IDtoEX_funct  <= funct;
      IDtoEX_valid  <= 1'b1;
    end
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-003 IFtoID_PC  input  32  PC+4 of the fetched instruction.
REQ-004 IFtoID_inst  input  32  fetched instruction word.
REQ-005 EX_MemRead, EX_RegWrite  input  1 each  control bits of the instruction in EX.
REQ-006 EX_WriteReg  input  5  destination register of the instruction in EX.
REQ-007 WB_RegWrite  input  1; WB_WriteReg  input  5; WB_WriteData  input  32  register-file write port.
REQ-008 PCWrite  output  1  PC update enable to fetch (0 = hold PC).
REQ-009 PCSrc  output  1  1 = fetch takes Branch as next PC.
REQ-010 Branch  output  32  branch target address.
REQ-011 IDtoEX_PC, IDtoEX_rsData, IDtoEX_rtData, IDtoEX_imm  output  32 each  registered ID/EX payload.
REQ-012 IDtoEX_rs, IDtoEX_rt, IDtoEX_rd  output  5 each; IDtoEX_op, IDtoEX_funct  output  6 each; IDtoEX_valid  output  1.

Function
REQ-013 Internal IF/ID register (pc, inst) SHALL capture IFtoID_PC/IFtoID_inst each rising edge unless stalled or flushed.
REQ-014 Field decode from IF/ID inst: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm = sign-extended [15:0].
REQ-015 Register file SHALL be 32x32; register 0 reads 0 always and ignores writes.
REQ-016 Write occurs on rising edge when WB_RegWrite=1 and WB_WriteReg!=0.
REQ-017 Same-cycle read of the register being written SHALL return WB_WriteData (write-through bypass).
REQ-018 Load-use stall: EX_MemRead=1, EX_WriteReg!=0, EX_WriteReg equals rs or rt -> stall.
REQ-019 Branch stall: op is beq (6'h04) or bne (6'h05), EX_RegWrite=1, EX_WriteReg!=0, equals rs or rt -> stall.
REQ-020 During stall: PCWrite=0, IF/ID holds, PCSrc=0, ID/EX loads a bubble (valid=0, all payload 0).
REQ-021 Without stall PCWrite=1 and ID/EX loads decoded fields, rs/rt read data, pc, with valid=1.
REQ-022 Branch = IF/ID pc + (imm << 2), 32-bit wrap-around, combinational, always driven.
REQ-023 PCSrc=1 combinationally when not stalled and (beq with rsData==rtData or bne with rsData!=rtData).
REQ-024 PCSrc=1 SHALL flush: IF/ID loads pc=0, inst=0 (nop) at the next edge; the branch itself still enters ID/EX.
REQ-025 Stall takes priority over branch resolution; branch re-evaluates after the stall clears.
REQ-026 Latency: IF/ID input to ID/EX output = 2 rising edges absent stall.

Reset
REQ-027 rst=0 SHALL immediately clear IF/ID (pc=0, inst=0), all ID/EX outputs to 0 (valid=0), and all 32 registers to 0.
REQ-028 During reset PCWrite=1, PCSrc=0, Branch=0; reset mid-stall or mid-flush discards all in-flight state.
REQ-029 First capture occurs on the first rising edge after rst returns to 1.

Verification
REQ-030 WB writes r5=0x1234 while ID reads rs=5 same cycle -> IDtoEX_rsData=0x00001234 after edge.
REQ-031 EX_MemRead=1, EX_WriteReg=8, ID inst add rd,r8,r9 -> PCWrite=0 one cycle, one bubble (valid=0), inst re-issues next cycle.
REQ-032 beq r1,r2 offset 3, r1=r2=7, pc=0x100 -> PCSrc=1, Branch=0x10C; next IF/ID inst=0.
REQ-033 bne r1,r2 with r1=r2 -> PCSrc=0, no flush; offset 0xFFFF at pc=0x100 -> Branch=0xFC.
REQ-034 Write to r0 with 0xFFFFFFFF -> subsequent read of r0 =0.
REQ-035 Assert rst=0 mid-stall between edges -> all outputs reset values immediately, no clock needed.
